// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, optional parity and a one-deep holding register.
// Frames that finish while the holding register is still full are dropped.
package uart_rx_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } e_fsm_state;
endpackage

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic ODD = (PARITY_ODD != 0);
  localparam logic PEN = (PARITY_EN != 0);

  e_fsm_state state_q, state_d;
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] os_q, os_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic par_o_q, par_o_d;
  logic frm_o_q, frm_o_d;
  logic ovr_q, ovr_d;
  logic tick;
  logic done;
  logic rx_s;

  assign rx_s = sync2_q;
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    sync1_d = rx_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    os_d    = tick ? os_q + 4'd1 : os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    data_d  = data_q;
    valid_d = valid_q;
    par_o_d = par_o_q;
    frm_o_d = frm_o_q;
    ovr_d   = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = START;
          div_d   = '0;
          os_d    = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (tick && os_q == 4'd7) begin
          state_d = rx_s ? IDLE : DATA;
          os_d    = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick && os_q == 4'd15) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == LAST_BIT) begin
            state_d = PEN ? PARITY : STOP;
            os_d    = '0;
            bit_d   = '0;
          end
        end
      end
      PARITY: begin
        if (tick && os_q == 4'd15) begin
          perr_d  = rx_s ^ (^shift_q) ^ ODD;
          state_d = STOP;
          os_d    = '0;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (tick && os_q == 4'd15) begin
          done    = 1'b1;
          state_d = IDLE;
          os_d    = '0;
          bit_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Holding register: a consumer pop and a new load may share a cycle
    if (done && (!valid_q || rx_ready_i)) begin
      data_d  = shift_q;
      par_o_d = perr_d;
      frm_o_d = ~rx_s;
      valid_d = 1'b1;
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      par_o_q <= 1'b0;
      frm_o_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      div_q   <= div_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      par_o_q <= par_o_d;
      frm_o_q <= frm_o_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign parity_err_o = par_o_q;
  assign frame_err_o  = frm_o_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: randomized and directed frames against a
// frame-level reference model (bits -> data, parity and stop flags).
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_checks;
  int n_fail;
  int cyc;
  int rise_cyc;
  int start_cyc;
  int vcnt;
  int ocnt;
  logic vprev;
  logic [9:0] got[$];
  logic [9:0] exp[$];

  uart_rx #(
    .CLK_DIV(4),
    .DATA_BITS(8),
    .PARITY_EN(1),
    .PARITY_ODD(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_i(rx_i),
    .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i),
    .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    vprev = 1'b0;
    vcnt = 0;
    ocnt = 0;
    rise_cyc = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid_o && !vprev) rise_cyc = cyc;
      if (rx_valid_o) vcnt++;
      if (rx_valid_o && rx_ready_i)
        got.push_back({parity_err_o, frame_err_o, rx_data_o});
      if (overrun_o) ocnt++;
    end
    vprev = rx_valid_o;
  end

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Model: even parity bit = odd count of ones; stop LOW is a frame error
  task automatic send_frame(input logic [7:0] d, input logic flip,
                            input logic stop);
    logic pb;
    logic perr;
    pb = ($countones(d) % 2 == 1) ^ flip;
    perr = (pb != ($countones(d) % 2 == 1));
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pb);
    send_bit(stop);
    rx_i = 1'b1;
    exp.push_back({perr, ~stop, d});
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic clear_logs;
    got.delete();
    exp.delete();
    vcnt = 0;
    ocnt = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx_i = 1'b1;
    rx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000",
        {rx_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o});
    end
    n_checks++;
    if (rx_data_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data got %h want 00", rx_data_o);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic;
    clear_logs();
    send_frame(8'hA5, 1'b0, 1'b1);
    n_checks++;
    if (got.size() != 1 || got[0] !== {2'b00, 8'hA5}) begin
      n_fail++;
      $display("FAIL basic_a5 got %0d items first %h want 0a5",
        got.size(), (got.size() > 0) ? got[0] : 10'h3ff);
    end
    n_checks++;
    if (vcnt != 1) begin
      n_fail++;
      $display("FAIL basic_valid_len got %0d want 1", vcnt);
    end
    n_checks++;
    if (rise_cyc - start_cyc < 672 || rise_cyc - start_cyc > 680) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 672..680",
        rise_cyc - start_cyc);
    end
  endtask

  task automatic test_parity_err;
    clear_logs();
    send_frame(8'h3C, 1'b1, 1'b1);
    n_checks++;
    if (got.size() != 1 || got[0] !== exp[0] || got[0] !== {2'b10, 8'h3C}) begin
      n_fail++;
      $display("FAIL parity_3c got %0d items first %h want 23c",
        got.size(), (got.size() > 0) ? got[0] : 10'h3ff);
    end
  endtask

  task automatic test_frame_err;
    clear_logs();
    send_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1);
    n_checks++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL frame_count got %0d want 2", got.size());
    end else begin
      n_checks++;
      if (got[0] !== {2'b01, 8'h55}) begin
        n_fail++;
        $display("FAIL frame_55 got %h want 155", got[0]);
      end
      n_checks++;
      if (got[1] !== {2'b00, 8'h0F}) begin
        n_fail++;
        $display("FAIL frame_0f got %h want 00f", got[1]);
      end
    end
  endtask

  task automatic test_glitch;
    clear_logs();
    rx_i = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy got %b want 1", busy_o);
    end
    repeat (8) @(negedge clk);
    rx_i = 1'b1;
    repeat (100) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || vcnt != 0) begin
      n_fail++;
      $display("FAIL glitch_idle got busy %b valid_cycles %0d want 0 0",
        busy_o, vcnt);
    end
  endtask

  task automatic test_random;
    logic [7:0] d;
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      send_frame(d, ($urandom_range(3) == 0), ($urandom_range(3) != 0));
    end
    n_checks++;
    if (got.size() != exp.size()) begin
      n_fail++;
      $display("FAIL rand_count got %0d want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (got[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL rand_frame%0d got %h want %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_overrun;
    clear_logs();
    rx_ready_i = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    n_checks++;
    if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h11) begin
      n_fail++;
      $display("FAIL ovr_hold got valid %b data %h want 1 11",
        rx_valid_o, rx_data_o);
    end
    n_checks++;
    if (ocnt != 1) begin
      n_fail++;
      $display("FAIL ovr_pulses got %0d want 1", ocnt);
    end
    @(posedge clk);
    #1 rx_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (got.size() != 1 || got[0] !== {2'b00, 8'h11} || rx_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_accept got %0d items valid %b want 1 item 011 valid 0",
        got.size(), rx_valid_o);
    end
  endtask

  task automatic test_reset_mid;
    clear_logs();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async got busy %b valid %b want 0 0",
        busy_o, rx_valid_o);
    end
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (8 * BIT_CLKS) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1);
    n_checks++;
    if (got.size() != 1 || got[0] !== {2'b00, 8'h81}) begin
      n_fail++;
      $display("FAIL rstmid_81 got %0d items first %h want 081",
        got.size(), (got.size() > 0) ? got[0] : 10'h3ff);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    rx_i = 1'b1;
    rx_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
